// File: rtl/rng_word_packer_pkg.sv
// Shared defaults for the random-bit packer, whitening stage and host interface.
package rng_word_packer_pkg;
   localparam int RNG_WORD_W     = 8;
   localparam int RNG_FIFO_DEPTH = 4;
   localparam int RNG_CNT_W      = 8;
endpackage

// File: rtl/rng_word_packer_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module rng_word_fifo
   import rng_word_packer_pkg::*;
#(
   parameter int WIDTH = RNG_WORD_W,
   parameter int DEPTH = RNG_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (level == '0);
   assign full     = (level == LW'(DEPTH));
   assign do_pop   = pop & ~empty & ~clr;
   assign do_push  = push & (~full | do_pop) & ~clr;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + LW'(1);
         else if (do_pop && !do_push) level <= level - LW'(1);
      end
   end

   // Storage is data only; validity comes from level, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/rng_word_packer.sv
// Packs a valid/bit stream LSB-first into words, buffers them, and counts words lost to a full FIFO.
module rng_word_packer
   import rng_word_packer_pkg::*;
#(
   parameter int WORD_W = RNG_WORD_W,
   parameter int DEPTH  = RNG_FIFO_DEPTH,
   parameter int CNT_W  = RNG_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   input  logic                    i_bit,
   input  logic                    i_clr,
   output logic                    o_valid,
   output logic [WORD_W-1:0]       o_data,
   input  logic                    i_ready,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_overflow,
   output logic [CNT_W-1:0]        o_drop_cnt
);
   localparam int BW = $clog2(WORD_W);
   localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

   logic [BW-1:0]     bit_cnt;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_nxt;
   logic              word_done;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_ok;
   logic              drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      shreg_nxt          = shreg;
      shreg_nxt[bit_cnt] = i_bit;
   end

   assign word_done = i_valid & (bit_cnt == LAST) & ~i_clr;
   assign o_valid   = ~fifo_empty;
   assign pop_ok    = o_valid & i_ready;
   // The source cannot stall, so a completed word with nowhere to go is lost.
   assign drop      = word_done & fifo_full & ~pop_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else if (i_clr) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         if (i_valid) begin
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + BW'(1);
            shreg   <= (bit_cnt == LAST) ? '0 : shreg_nxt;
         end
         if (drop) begin
            o_overflow <= 1'b1;
            o_drop_cnt <= sat_inc(o_drop_cnt);
         end
      end
   end

   rng_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (i_clr),
      .push      (word_done),
      .push_data (shreg_nxt),
      .pop       (i_ready),
      .pop_data  (o_data),
      .level     (o_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
endmodule
